spike_dispatch_sink: RTL and testbench
======================================

SPIKE_DISPATCH_SINK -- requirements
Module: spike_dispatch_sink

Interface
REQ-001 SHALL have parameter NUM_OUT, default 8, meaning the number of network output bits; legal range is 1 to 1024.
REQ-002 SHALL have parameter COUNT_FIRST, default 0, where 0 means the count word trails the indices and 1 means it heads them.
REQ-003 SHALL derive localparam SNK_WIDTH = $clog2(NUM_OUT+1), used for both index and count words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port net_valid, input, 1 bit: network frame available.
REQ-007 SHALL have port net_ready, output, 1 bit: block accepts a frame.
REQ-008 SHALL have port net_out, input, NUM_OUT bits: fire vector; bit i set means output i fired.
REQ-009 SHALL have port snk_valid, output, 1 bit: the snk word is valid.
REQ-010 SHALL have port snk_ready, input, 1 bit: downstream accepts the snk word.
REQ-011 SHALL have port snk, output, SNK_WIDTH bits: index word or count word.

Function
REQ-012 SHALL capture net_out on the frame handshake, defined as the cycle where net_valid and net_ready are both high.
REQ-013 SHALL implement FSM states IDLE, EMIT_IDX and EMIT_CNT.
- IDLE to the first state on the frame handshake.
- EMIT_IDX to EMIT_CNT (COUNT_FIRST=0) or to IDLE/next frame (COUNT_FIRST=1) after the last index word's handshake.
- EMIT_CNT to EMIT_IDX (COUNT_FIRST=1, count>0) or to IDLE/next frame.
REQ-014 SHALL assert snk_valid first in the cycle after the frame handshake (latency 1), with no bubbles between words of a frame while snk_ready is high.
REQ-015 SHALL emit the indices of the set bits in strictly ascending order, one per snk handshake, using a find-first-set over a held mask whose lowest set bit clears on each handshake.
REQ-016 SHALL set the count word to the popcount of the captured vector, computed at capture and exact to NUM_OUT, with no truncation.
REQ-017 SHALL, for an all-zero frame, emit exactly one word: count 0, with no index words in either mode.
REQ-018 SHALL hold snk stable and keep snk_valid high while snk_valid is high and snk_ready is low.
REQ-019 SHALL drive net_ready high in IDLE, or in the cycle the final word of a frame handshakes, and low otherwise.
REQ-020 SHALL, when the final-word handshake and the next frame handshake occur in the same cycle, start the next frame's first word in the next cycle with no idle cycle.
REQ-021 SHALL ignore net_out while net_ready is low.
REQ-022 SHALL keep snk_valid low in IDLE; in that state snk is don't-care but driven to 0.

Reset
REQ-023 SHALL, with rst high at a clock edge, force state to IDLE, clear the mask and count, and drive snk_valid=0, snk=0 and net_ready=0 during reset.
REQ-024 SHALL drive net_ready=1 in the first cycle after rst deasserts.
REQ-025 SHALL, on reset asserted mid-frame, discard the frame with no partial continuation afterwards.

Configuration
REQ-026 SHALL, with macro SPIKE_DISPATCH_SINK_LAST_EN defined, add output port snk_last (1 bit), high with snk_valid exactly on the final word of each frame and reset to 0.
REQ-027 SHALL, without SPIKE_DISPATCH_SINK_LAST_EN, not have port snk_last, with all other behaviour identical.

Verification
REQ-028 SHALL cover: NUM_OUT=8, COUNT_FIRST=0, net_out=8'b1000_0101, snk_ready=1 -> snk 0,2,7,3 on four consecutive cycles starting 1 cycle after accept.
REQ-029 SHALL cover: same frame with COUNT_FIRST=1 -> snk 3,0,2,7; with the macro defined, snk_last is high only on word 7.
REQ-030 SHALL cover: net_out=0 in both modes -> a single word 0, and net_ready is high in the same cycle as its handshake.
REQ-031 SHALL cover: net_out=8'hFF, COUNT_FIRST=0, with snk_ready low for 3 cycles on word 4 -> snk 0..7 then 8 (SNK_WIDTH=4), and word 4 held stable for all 3 stall cycles.
REQ-032 SHALL cover: back-to-back frames 8'h01 then 8'h80 with net_valid held high -> snk 0,1,7,1 on consecutive cycles with no gap.
REQ-033 SHALL cover: rst pulsed after the second word of 8'hFF -> snk_valid is low the next cycle and a new frame 8'h02 yields 1,1 only.

Source files
------------

// File: rtl/spike_dispatch_sink.sv
// Spike dispatch sink: serialises a captured fire vector into ascending index words plus a
// popcount word. Optional snk_last output enabled by defining SPIKE_DISPATCH_SINK_LAST_EN.
module spike_dispatch_sink #(
    parameter int unsigned NUM_OUT     = 8,
    parameter int unsigned COUNT_FIRST = 0,
    localparam int unsigned SNK_WIDTH  = $clog2(NUM_OUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 net_valid,
    output logic                 net_ready,
    input  logic [NUM_OUT-1:0]   net_out,
    output logic                 snk_valid,
    input  logic                 snk_ready,
    output logic [SNK_WIDTH-1:0] snk
`ifdef SPIKE_DISPATCH_SINK_LAST_EN
    ,
    output logic                 snk_last
`endif
);

    localparam bit CntFirst = (COUNT_FIRST != 0);

    typedef enum logic [1:0] {StIdle, StEmitIdx, StEmitCnt} state_e;

    state_e               state_q;
    logic [NUM_OUT-1:0]   mask_q;
    logic [SNK_WIDTH-1:0] cnt_q;
    logic [SNK_WIDTH-1:0] snk_q;
    logic                 snk_valid_q;
    logic                 last_q;

    function automatic logic [SNK_WIDTH-1:0] ffs(input logic [NUM_OUT-1:0] v);
        logic [SNK_WIDTH-1:0] r;
        r = '0;
        for (int i = int'(NUM_OUT) - 1; i >= 0; i--) begin
            if (v[i]) r = SNK_WIDTH'(i);
        end
        return r;
    endfunction

    function automatic logic [SNK_WIDTH-1:0] popcnt(input logic [NUM_OUT-1:0] v);
        logic [SNK_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < int'(NUM_OUT); i++) begin
            r = r + SNK_WIDTH'(v[i]);
        end
        return r;
    endfunction

    function automatic logic at_most_one(input logic [NUM_OUT-1:0] v);
        return (v & (v - NUM_OUT'(1))) == '0;
    endfunction

    logic                 net_hs;
    logic                 snk_hs;
    logic                 frame_done;
    logic [NUM_OUT-1:0]   mask_nxt;
    logic                 in_zero;
    state_e               ld_state;
    logic [SNK_WIDTH-1:0] ld_snk;

    assign snk_hs     = snk_valid_q && snk_ready;
    assign frame_done = (state_q == StIdle) || (snk_hs && last_q);
    assign net_ready  = !rst && frame_done;
    assign net_hs     = net_valid && net_ready;

    // Mask with its lowest set bit cleared: what remains after the current index word.
    assign mask_nxt = mask_q & (mask_q - NUM_OUT'(1));

    // An all-zero frame is a lone count word in either mode.
    assign in_zero  = (net_out == '0);
    assign ld_state = (CntFirst || in_zero) ? StEmitCnt : StEmitIdx;
    assign ld_snk   = (CntFirst || in_zero) ? popcnt(net_out) : ffs(net_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            cnt_q       <= '0;
            snk_q       <= '0;
            snk_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else if (net_hs) begin
            state_q     <= ld_state;
            mask_q      <= net_out;
            cnt_q       <= popcnt(net_out);
            snk_q       <= ld_snk;
            snk_valid_q <= 1'b1;
            last_q      <= in_zero;
        end else if (frame_done) begin
            state_q     <= StIdle;
            mask_q      <= '0;
            cnt_q       <= '0;
            snk_q       <= '0;
            snk_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else if (snk_hs) begin
            // Only non-final words reach here; the final word is covered by frame_done.
            unique case (state_q)
                StEmitIdx: begin
                    mask_q <= mask_nxt;
                    if (mask_nxt != '0) begin
                        snk_q  <= ffs(mask_nxt);
                        last_q <= CntFirst && at_most_one(mask_nxt);
                    end else begin
                        state_q <= StEmitCnt;
                        snk_q   <= cnt_q;
                        last_q  <= 1'b1;
                    end
                end
                StEmitCnt: begin
                    state_q <= StEmitIdx;
                    snk_q   <= ffs(mask_q);
                    last_q  <= at_most_one(mask_q);
                end
                default: begin
                    state_q     <= StIdle;
                    snk_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign snk_valid = snk_valid_q;
    assign snk       = snk_q;

`ifdef SPIKE_DISPATCH_SINK_LAST_EN
    assign snk_last = last_q;
`endif

endmodule

// File: tb/tb_spike_dispatch_sink.sv
// Scoreboard bench for spike_dispatch_sink: dut0 has COUNT_FIRST=0, dut1 has COUNT_FIRST=1.
module tb_spike_dispatch_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic       net_valid [2];
    logic       net_ready [2];
    logic [7:0] net_out   [2];
    logic       snk_valid [2];
    logic       snk_ready [2];
    logic [3:0] snk       [2];
`ifdef SPIKE_DISPATCH_SINK_LAST_EN
    logic       snk_last  [2];
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int exp_q0[$];
    int exp_q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        spike_dispatch_sink #(
            .NUM_OUT    (8),
            .COUNT_FIRST(g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .net_valid(net_valid[g]),
            .net_ready(net_ready[g]),
            .net_out  (net_out[g]),
            .snk_valid(snk_valid[g]),
            .snk_ready(snk_ready[g]),
            .snk      (snk[g])
`ifdef SPIKE_DISPATCH_SINK_LAST_EN
            ,
            .snk_last (snk_last[g])
`endif
        );
    end

    task automatic check(input string name, input int g, input logic [31:0] act,
                         input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, g, act, req, $time);
        end
    endtask

    function automatic int qsize(input int g);
        return (g == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic int qpop(input int g);
        return (g == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
    endfunction

    task automatic push(input int g, input int w, input bit last);
        int v;
        v = w | (int'(last) << 16);
        if (g == 0) exp_q0.push_back(v);
        else exp_q1.push_back(v);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offers a frame and returns just after the accepting edge; c0 is the cycle of word 0.
    task automatic send(input int g, input logic [7:0] v, input bit hold, output int c0);
        bit ok;
        ok = 1'b0;
        net_valid[g] = 1'b1;
        net_out[g]   = v;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = net_ready[g];
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL accept_timeout dut%0d: net_ready never high for frame %h", g, v);
        end
        @(posedge clk);
        #1;
        c0 = cyc;
        if (!hold) begin
            net_valid[g] = 1'b0;
            net_out[g]   = 8'hA5;
        end
    endtask

    task automatic drain(input int g, input int c0, input int n);
        wait_until(c0 + n);
        check("drain", g, qsize(g), 0);
    endtask

    initial begin : monitor
        bit   stalled [2];
        logic [3:0] held [2];
        int   e;
        for (int g = 0; g < 2; g++) begin
            stalled[g] = 1'b0;
            held[g]    = '0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (stalled[g] && snk_valid[g] === 1'b1) check("stall_hold", g, snk[g], held[g]);
                stalled[g] = (snk_valid[g] === 1'b1) && (snk_ready[g] === 1'b0);
                held[g]    = snk[g];
                if (snk_valid[g] === 1'b1 && snk_ready[g] === 1'b1) begin
                    if (qsize(g) == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_word dut%0d: got %0d, expected no word", g,
                                 snk[g]);
                    end else begin
                        e = qpop(g);
                        check("snk_word", g, snk[g], e & 'hFFFF);
                        check("net_ready_on_word", g, net_ready[g], (e >> 16) & 1);
`ifdef SPIKE_DISPATCH_SINK_LAST_EN
                        check("snk_last", g, snk_last[g], (e >> 16) & 1);
`endif
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int c0;
        int c1;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            net_valid[g] = 1'b0;
            net_out[g]   = 8'h00;
            snk_ready[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset_snk_valid", g, snk_valid[g], 0);
            check("reset_snk", g, snk[g], 0);
            check("reset_net_ready", g, net_ready[g], 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) check("ready_after_reset", g, net_ready[g], 1);
        @(posedge clk);
        #1;

        // 8'b1000_0101, count last then count first
        push(0, 0, 0); push(0, 2, 0); push(0, 7, 0); push(0, 3, 1);
        send(0, 8'h85, 0, c0);
        drain(0, c0, 4);
        push(1, 3, 0); push(1, 0, 0); push(1, 2, 0); push(1, 7, 1);
        send(1, 8'h85, 0, c0);
        drain(1, c0, 4);

        // all-zero frames: lone count word
        push(0, 0, 1);
        send(0, 8'h00, 0, c0);
        drain(0, c0, 1);
        push(1, 0, 1);
        send(1, 8'h00, 0, c0);
        drain(1, c0, 1);

        // single high bit, count first
        push(1, 1, 0); push(1, 7, 1);
        send(1, 8'h80, 0, c0);
        drain(1, c0, 2);

        // zero frame followed back-to-back by 8'h01, count first
        push(1, 0, 1); push(1, 1, 0); push(1, 0, 1);
        send(1, 8'h00, 1, c0);
        send(1, 8'h01, 0, c1);
        drain(1, c0, 3);

        // back-to-back 8'h01, 8'h80 with net_valid held
        push(0, 0, 0); push(0, 1, 1); push(0, 7, 0); push(0, 1, 1);
        send(0, 8'h01, 1, c0);
        send(0, 8'h80, 0, c1);
        drain(0, c0, 4);

        // 8'hFF with word 4 stalled for three cycles
        for (int i = 0; i < 8; i++) push(0, i, 0);
        push(0, 8, 1);
        send(0, 8'hFF, 0, c0);
        wait_until(c0 + 4);
        snk_ready[0] = 1'b0;
        wait_until(c0 + 7);
        snk_ready[0] = 1'b1;
        drain(0, c0, 12);

        // reset after the second word of 8'hFF, then a fresh 8'h02
        push(0, 0, 0); push(0, 1, 0);
        send(0, 8'hFF, 0, c0);
        wait_until(c0 + 2);
        rst          = 1'b1;
        snk_ready[0] = 1'b0;
        @(negedge clk);
        check("ready_in_reset", 0, net_ready[0], 0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        snk_ready[0] = 1'b1;
        @(negedge clk);
        check("valid_after_midframe_reset", 0, snk_valid[0], 0);
        check("snk_after_midframe_reset", 0, snk[0], 0);
        check("ready_after_midframe_reset", 0, net_ready[0], 1);
        check("queue_after_midframe_reset", 0, qsize(0), 0);
        @(posedge clk);
        #1;
        push(0, 1, 0); push(0, 1, 1);
        send(0, 8'h02, 0, c0);
        drain(0, c0, 2);

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
        $finish;
    end

endmodule
